if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Holds the program counter and computes PC+4.
- Selects the next PC from sequential, branch-target (output of the ID-stage branch-target adder) or jump-target.
- Drives the instruction-memory address and registers the fetched instruction plus PC+4 into the IF/ID pipeline register consumed by decode and the branch-target adder.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- branch_taken  in  1  ID-stage branch resolved taken this cycle.
- branch_target  in  32  branch target from the branch-target adder (sign-extended offset<<2 plus IF/ID PC+4).
- jump  in  1  ID-stage J/JAL decoded this cycle.
- jump_target  in  32  {pc4[31:28], instr_index, 2'b00}.
- imem_addr  out  32  instruction-memory address (= current PC), combinational from the PC register.
- imem_rdata  in  32  instruction word; combinational (same-cycle) read.
- if_id_pc4  out  32  registered PC+4 of the fetched instruction.
- if_id_instr  out  32  registered instruction word.
- if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.

Behaviour:
- Reset (async assert, sync-safe deassert by the system):
  - pc=RESET_PC, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - Reset asserted mid-operation discards any pending redirect or stall immediately.
- pc4 = pc + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0, no flag).
- Next-PC priority, evaluated each rising edge:
  1. redirect = branch_taken | jump. pc <= branch_taken ? branch_target : jump_target (branch wins if both assert). Target bits [1:0] are forced to 0.
  2. else if stall: pc holds.
  3. else: pc <= pc4.
- IF/ID update, same edge:
  - redirect: IF/ID flushed. if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc4=0.
  - Redirect overrides stall; the hazard unit guarantees branch_taken is not asserted with a stale ID operand.
  - else if stall: IF/ID holds all fields.
  - else: if_id_instr<=imem_rdata, if_id_pc4<=pc4, if_id_valid<=1.
- Latency: the instruction at PC N appears on if_id_* exactly one cycle after imem_addr=N, absent stall or redirect.
- Redirect penalty: exactly one bubble. The cycle after the redirect edge, imem_addr=target; the next edge loads the target instruction.
- First cycle after reset release: imem_addr=RESET_PC, if_id_valid=0.
- Stall held for N cycles: pc and IF/ID remain constant for all N cycles with no fetch side effects. Resumes at the next edge with stall=0.
- No X-propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], perf_stall_cnt[31:0], perf_flush_cnt[31:0], all reset to 0.
  - Increment rules per edge (mutually exclusive, following the next-PC priority): fetch when an instruction is loaded into IF/ID; stall when stall&~redirect; flush when redirect.
  - Counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package mips_pkg:
  - constants: INSTR_W=32, ADDR_W=32, NOP_INSTR value, PC_INC=4.
  - typedef if_id_t {pc4, instr, valid} reused by the decode stage.
- Natural sub-module: if_id_reg. It is the IF/ID pipeline register with hold (stall) and synchronous flush, and is reused by the ID/EX register pattern.
- The PC register and next-PC mux stay in the top.

Test Plan:
- Reset with RESET_PC=32'h0040_0000 → imem_addr=0x00400000, if_id_valid=0, if_id_instr=0. After 3 free cycles, imem_addr=0x0040000C and if_id_pc4=0x0040000C.
- stall=1 for 4 cycles at pc=0x20 → imem_addr stays 0x20 and IF/ID unchanged. Release → next edge loads instr@0x20 and if_id_pc4=0x24.
- branch_taken=1, branch_target=0x100 at pc=0x40 → next cycle imem_addr=0x100, if_id_valid=0 (bubble). Following edge: if_id_pc4=0x104.
- branch_taken=1 and stall=1 together (target 0x80) → pc=0x80 and IF/ID flushed (redirect beats stall). branch_taken=1 and jump=1 (0x80 vs 0x200) → pc=0x80.
- pc=32'hFFFF_FFFC, free run → imem_addr=0 next cycle, and if_id_pc4=0. Target 0x103 → pc=0x100.
- IF_PERF_CNT_EN: 5 fetches, 2 stalls, 1 redirect → fetch=5, stall=2, flush=1. Async reset mid-run → all counters 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   INSTR_W / ADDR_W : instruction and address widths
//   NOP_INSTR        : bubble encoding (sll $0,$0,0)
//   PC_INC           : sequential PC increment
//   ALIGN_MASK       : clears the byte-offset bits of a word address
//   if_id_t          : IF/ID pipeline register contents, reused by decode
//   make_bubble()    : builds the flushed/reset IF/ID value
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_INC     = 32'd4;
  localparam logic [ADDR_W-1:0]  ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  // A bubble carries no PC, the configured NOP and valid=0.
  function automatic if_id_t make_bubble(input logic [INSTR_W-1:0] nop);
    if_id_t b;
    b.pc4   = 32'h0000_0000;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and synchronous flush.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, loads a bubble
//   hold  : keep the current contents
//   flush : load a bubble (wins over hold)
//   d     : next contents
//   q     : registered contents
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_VAL = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Pipeline register: flush beats hold so a redirect always kills the wrong-path fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= make_bubble(NOP_VAL);
    end else if (flush) begin
      q <= make_bubble(NOP_VAL);
    end else if (hold) begin
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, selects the next PC (branch > jump > stall > PC+4), drives
// the instruction-memory address and registers the fetch into IF/ID.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   stall                       : hazard hold of PC and IF/ID
//   branch_taken, branch_target : ID-stage taken branch and its target
//   jump, jump_target           : ID-stage J/JAL and its target
//   imem_addr / imem_rdata      : instruction memory (combinational read)
//   if_id_pc4/instr/valid       : IF/ID pipeline register outputs
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt, perf_stall_cnt and
// perf_flush_cnt (wrapping event counters).
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc4_s;
  logic [ADDR_W-1:0] redirect_tgt_s;
  logic [ADDR_W-1:0] next_pc_s;
  logic              redirect_s;
  if_id_t            if_id_d_s;
  if_id_t            if_id_q_s;

  // Sequential address wraps silently at 2^32.
  assign pc4_s          = pc_r + PC_INC;
  assign redirect_s     = branch_taken | jump;
  // Branch wins over jump; targets are forced word-aligned.
  assign redirect_tgt_s = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;

  // Next-PC select: redirect, then stall hold, then sequential.
  always_comb begin
    next_pc_s = pc4_s;
    if (redirect_s) begin
      next_pc_s = redirect_tgt_s;
    end else if (stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign imem_addr = pc_r;

  assign if_id_d_s.pc4   = pc4_s;
  assign if_id_d_s.instr = imem_rdata;
  assign if_id_d_s.valid = 1'b1;

  if_id_reg #(
    .NOP_VAL (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (stall),
    .flush (redirect_s),
    .d     (if_id_d_s),
    .q     (if_id_q_s)
  );

  assign if_id_pc4   = if_id_q_s.pc4;
  assign if_id_instr = if_id_q_s.instr;
  assign if_id_valid = if_id_q_s.valid;

`ifdef IF_PERF_CNT_EN
  // Event counters: exactly one of fetch/stall/flush advances per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else if (redirect_s) begin
      perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end else if (stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
// Instruction memory is modelled as imem_rdata = imem_addr ^ 32'h1234_5678;
// expected instruction words below are hand-computed from that rule.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_stage #(
    .RESET_PC  (32'h0040_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  assign imem_rdata = imem_addr ^ 32'h1234_5678;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to_jump(input logic [31:0] tgt);
    jump = 1'b1; jump_target = tgt;
    step();
    jump = 1'b0; jump_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    #1;
    n_cmp++; if (imem_addr !== 32'h0040_0000) begin n_bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, 32'h0040_0000); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", if_id_instr); end
    n_cmp++; if (if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4: got %h want 0", if_id_pc4); end
    step(); step();
    @(negedge clk); reset = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h0040_0000) begin n_bad++; $display("FAIL rel_addr: got %h want %h", imem_addr, 32'h0040_0000); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rel_valid: got %b want 0", if_id_valid); end
    step();
    n_cmp++; if (if_id_instr !== 32'h1274_5678) begin n_bad++; $display("FAIL first_instr: got %h want %h", if_id_instr, 32'h1274_5678); end
    n_cmp++; if (if_id_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", if_id_valid); end
    step(); step();
    n_cmp++; if (imem_addr !== 32'h0040_000C) begin n_bad++; $display("FAIL run3_addr: got %h want %h", imem_addr, 32'h0040_000C); end
    n_cmp++; if (if_id_pc4 !== 32'h0040_000C) begin n_bad++; $display("FAIL run3_pc4: got %h want %h", if_id_pc4, 32'h0040_000C); end
    n_cmp++; if (if_id_instr !== 32'h1274_5670) begin n_bad++; $display("FAIL run3_instr: got %h want %h", if_id_instr, 32'h1274_5670); end
  endtask

  task automatic test_stall();
    redirect_to_jump(32'h0000_001C);
    step();  // pc=0x20, IF/ID holds instr@0x1C
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL stall_addr[%0d]: got %h want 20", i, imem_addr); end
      n_cmp++; if (if_id_pc4 !== 32'h20 || if_id_instr !== 32'h1234_5664 || if_id_valid !== 1'b1) begin
        n_bad++; $display("FAIL stall_ifid[%0d]: got %h/%h/%b want 20/12345664/1", i, if_id_pc4, if_id_instr, if_id_valid); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (if_id_pc4 !== 32'h24) begin n_bad++; $display("FAIL unstall_pc4: got %h want 24", if_id_pc4); end
    n_cmp++; if (if_id_instr !== 32'h1234_5658) begin n_bad++; $display("FAIL unstall_instr: got %h want 12345658", if_id_instr); end
    n_cmp++; if (imem_addr !== 32'h24) begin n_bad++; $display("FAIL unstall_addr: got %h want 24", imem_addr); end
  endtask

  task automatic test_branch();
    redirect_to_jump(32'h0000_0040);
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0; branch_target = 32'h0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_addr: got %h want 100", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
      n_bad++; $display("FAIL br_bubble: got %h/%h/%b want 0/0/0", if_id_pc4, if_id_instr, if_id_valid); end
    step();
    n_cmp++; if (if_id_pc4 !== 32'h104) begin n_bad++; $display("FAIL br_pc4: got %h want 104", if_id_pc4); end
    n_cmp++; if (if_id_instr !== 32'h1234_5778 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL br_instr: got %h/%b want 12345778/1", if_id_instr, if_id_valid); end
  endtask

  task automatic test_priority();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    stall = 1'b0;
    n_cmp++; if (imem_addr !== 32'h80) begin n_bad++; $display("FAIL brstall_addr: got %h want 80", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL brstall_flush: got %h/%b want 0/0", if_id_pc4, if_id_valid); end
    jump = 1'b1; jump_target = 32'h200;
    step();
    branch_taken = 1'b0; jump = 1'b0;
    n_cmp++; if (imem_addr !== 32'h80) begin n_bad++; $display("FAIL brjmp_addr: got %h want 80", imem_addr); end
    jump = 1'b1; jump_target = 32'h0000_0202;
    step();
    jump = 1'b0;
    n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL jmp_align: got %h want 200", imem_addr); end
  endtask

  task automatic test_wrap();
    redirect_to_jump(32'hFFFF_FFFC);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
    step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    n_cmp++; if (if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_pc4: got %h/%b want 0/1", if_id_pc4, if_id_valid); end
    n_cmp++; if (if_id_instr !== 32'hEDCB_A984) begin n_bad++; $display("FAIL wrap_instr: got %h want edcba984", if_id_instr); end
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_align: got %h want 100", imem_addr); end
  endtask

  task automatic test_async_reset();
    step();
    @(negedge clk); #2;
    reset = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    n_cmp++; if (imem_addr !== 32'h0040_0000) begin n_bad++; $display("FAIL arst_addr: got %h want 00400000", imem_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin n_bad++; $display("FAIL arst_ifid: got %h/%b want 0/0", if_id_pc4, if_id_valid); end
`ifdef IF_PERF_CNT_EN
    n_cmp++; if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      n_bad++; $display("FAIL arst_perf: got %0d/%0d/%0d want 0/0/0", perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt); end
`endif
    step();
    stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    @(negedge clk); reset = 1'b0;
    #1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    for (int i = 0; i < 5; i++) step();
    stall = 1'b1; step(); step(); stall = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h40; step(); branch_taken = 1'b0;
    n_cmp++; if (perf_fetch_cnt !== 32'd5) begin n_bad++; $display("FAIL perf_fetch: got %0d want 5", perf_fetch_cnt); end
    n_cmp++; if (perf_stall_cnt !== 32'd2) begin n_bad++; $display("FAIL perf_stall: got %0d want 2", perf_stall_cnt); end
    n_cmp++; if (perf_flush_cnt !== 32'd1) begin n_bad++; $display("FAIL perf_flush: got %0d want 1", perf_flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_priority();
    test_wrap();
    test_async_reset();
`ifdef IF_PERF_CNT_EN
    test_perf();
    test_async_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
